// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester memory data-port arbiter.
// Holds the FSM state encoding and the requester IDs.
package mem_arbiter_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      REQ_CPU    = 1'b0,
      REQ_LOADER = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, and on a tie
// the requester that was not served last wins.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic    req0,
   input  logic    req1,
   input  req_id_t last,
   output req_id_t winner,
   output logic    valid
);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      valid  = req0 | req1;
      winner = REQ_CPU;
      if (req0 && req1)
         winner = (last == REQ_CPU) ? REQ_LOADER : REQ_CPU;
      else if (req1)
         winner = REQ_LOADER;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory data port between the CPU load/store unit and the loader,
// granting round-robin and sequencing exactly one access per grant.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              oe_d,
   output logic              we,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_write,
   input  logic [DATA_W-1:0] data_read
);

   state_t  state;
   req_id_t rr_last;
   req_id_t owner;
   req_id_t winner;
   logic    win_valid;
   logic    we_lat;

   rr_arb2 u_rr_arb2 (
      .req0   (req0),
      .req1   (req1),
      .last   (rr_last),
      .winner (winner),
      .valid  (win_valid)
   );

   // NOTE: all outputs are registered, so each one is loaded on the edge that
   // enters the state it belongs to (e.g. we/oe_d are set while leaving IDLE).
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_last    <= REQ_LOADER;
         owner      <= REQ_CPU;
         we_lat     <= 1'b0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         oe_d       <= 1'b0;
         we         <= 1'b0;
         data_addr  <= '0;
         data_write <= '0;
         rdata      <= '0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (win_valid) begin
                  owner   <= winner;
                  rr_last <= winner;
                  state   <= ACCESS;
                  if (winner == REQ_CPU) begin
                     data_addr  <= addr0;
                     data_write <= wdata0;
                     we_lat     <= we0;
                     we         <= we0;
                     oe_d       <= ~we0;
                     gnt0       <= 1'b1;
                  end else begin
                     data_addr  <= addr1;
                     data_write <= wdata1;
                     we_lat     <= we1;
                     we         <= we1;
                     oe_d       <= ~we1;
                     gnt1       <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (we_lat) begin
                  we    <= 1'b0;
                  state <= RESP;
                  if (owner == REQ_CPU) ack0 <= 1'b1;
                  else                  ack1 <= 1'b1;
               end else begin
                  state <= RDWAIT;
               end
            end
            RDWAIT: begin
               // memory presents data_read one cycle after oe_d was seen
               rdata <= data_read;
               oe_d  <= 1'b0;
               state <= RESP;
               if (owner == REQ_CPU) ack0 <= 1'b1;
               else                  ack1 <= 1'b1;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory plus a timeline
// model of grants, acks and data derived from the arbitration rules.
module tb_mem_arbiter;

   localparam int DW = 8;
   localparam int AW = 10;

   typedef struct {
      bit            en;
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            start;
   } cmd_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, ack0, gnt1, ack1;
   logic [DW-1:0] rdata;
   logic          oe_d, we;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_write;
   logic [DW-1:0] data_read;

   int            n_checks = 0;
   int            n_errors = 0;
   int            m_last;
   logic [DW-1:0] ref_mem [0:1023];
   int            dut_gnt_log[$];
   int            gnt_cycle [0:1];

   mem_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .we0        (we0),
      .addr0      (addr0),
      .wdata0     (wdata0),
      .gnt0       (gnt0),
      .ack0       (ack0),
      .req1       (req1),
      .we1        (we1),
      .addr1      (addr1),
      .wdata1     (wdata1),
      .gnt1       (gnt1),
      .ack1       (ack1),
      .rdata      (rdata),
      .oe_d       (oe_d),
      .we         (we),
      .data_addr  (data_addr),
      .data_write (data_write),
      .data_read  (data_read)
   );

   always #5 clk = ~clk;

   // Behavioural data port of the memory, cleared with system reset.
   logic [DW-1:0] mem [0:1023];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         data_read <= '0;
      end else begin
         if (we)   mem[data_addr] <= data_write;
         if (oe_d) data_read      <= mem[data_addr];
      end
   end

   function automatic cmd_t cmd(input bit en, input bit w, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input int s);
      cmd_t c;
      c.en = en; c.w = w; c.a = a; c.d = d; c.start = s;
      return c;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      tick();
      tick();
      rst = 1'b0;
      m_last = 1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
   endtask

   // Drives up to two requests and checks every cycle against the timeline
   // model: gnt one cycle after an IDLE sample, ack 1 (write) or 2 (read)
   // cycles after gnt, IDLE one cycle after ack.
   task automatic serve(input cmd_t c0, input cmd_t c1);
      int            c = 0;
      bit            g0 = !c0.en;
      bit            g1 = !c1.en;
      bit            act = 1'b0;
      bit            done = 1'b0;
      int            g = -1;
      int            ak = -1;
      int            free_at = 0;
      int            own = 0;
      cmd_t          cur;
      logic [DW-1:0] rexp = '0;
      logic [5:0]    obs, exp_v;
      cur = c0;
      while (!done) begin
         if (c0.en && !g0 && c == c0.start) begin
            req0 = 1'b1; we0 = c0.w; addr0 = c0.a; wdata0 = c0.d;
         end
         if (c1.en && !g1 && c == c1.start) begin
            req1 = 1'b1; we1 = c1.w; addr1 = c1.a; wdata1 = c1.d;
         end
         if (c >= free_at && (req0 || req1)) begin
            if (req0 && req1) own = (m_last == 0) ? 1 : 0;
            else              own = req0 ? 0 : 1;
            cur     = (own == 0) ? c0 : c1;
            g       = c + 1;
            ak      = g + (cur.w ? 1 : 2);
            free_at = ak + 1;
            m_last  = own;
            act     = 1'b1;
            rexp    = ref_mem[cur.a];
            if (cur.w) ref_mem[cur.a] = cur.d;
         end
         tick();
         c++;
         obs   = {gnt0, gnt1, ack0, ack1, oe_d, we};
         exp_v = '0;
         if (act) begin
            if (c == g)           exp_v[(own == 0) ? 5 : 4] = 1'b1;
            if (c == ak)          exp_v[(own == 0) ? 3 : 2] = 1'b1;
            if (c >= g && c < ak) exp_v[cur.w ? 0 : 1] = 1'b1;
         end
         n_checks++;
         if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL handshake cycle %0d: {gnt0,gnt1,ack0,ack1,oe_d,we} got %b expected %b",
                     c, obs, exp_v);
         end
         if (act && c >= g) begin
            n_checks++;
            if (data_addr !== cur.a) begin
               n_errors++;
               $display("FAIL data_addr cycle %0d: got %0d expected %0d", c, data_addr, cur.a);
            end
         end
         if (act && c == g && cur.w) begin
            n_checks++;
            if (data_write !== cur.d) begin
               n_errors++;
               $display("FAIL data_write cycle %0d: got %h expected %h", c, data_write, cur.d);
            end
         end
         if (act && c == ak && !cur.w) begin
            n_checks++;
            if (rdata !== rexp) begin
               n_errors++;
               $display("FAIL rdata cycle %0d addr %0d: got %h expected %h", c, cur.a, rdata, rexp);
            end
         end
         if (gnt0 && req0) begin
            req0 = 1'b0; g0 = 1'b1; dut_gnt_log.push_back(0); gnt_cycle[0] = c;
         end
         if (gnt1 && req1) begin
            req1 = 1'b0; g1 = 1'b1; dut_gnt_log.push_back(1); gnt_cycle[1] = c;
         end
         if (g0 && g1 && c >= free_at) begin
            done = 1'b1;
         end else if (c >= 80) begin
            n_checks++;
            n_errors++;
            $display("FAIL serve_timeout: got no completion after %0d cycles, expected completion", c);
            req0 = 1'b0;
            req1 = 1'b0;
            done = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({gnt0, gnt1, ack0, ack1, oe_d, we} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b expected 000000", {gnt0, gnt1, ack0, ack1, oe_d, we});
      end
      n_checks++;
      if (data_addr !== '0 || data_write !== '0 || rdata !== '0) begin
         n_errors++;
         $display("FAIL reset_data: got addr %0d wdata %h rdata %h expected all zero",
                  data_addr, data_write, rdata);
      end
   endtask

   task automatic test_write_read();
      serve(cmd(1'b1, 1'b1, 10'd1, 8'h33, 0), cmd(1'b0, 1'b0, '0, '0, 0));
      serve(cmd(1'b1, 1'b0, 10'd1, 8'h00, 0), cmd(1'b0, 1'b0, '0, '0, 0));
   endtask

   task automatic test_simultaneous();
      int exp_q[$];
      exp_q = '{0, 1, 0, 1};
      do_reset();
      dut_gnt_log.delete();
      serve(cmd(1'b1, 1'b0, 10'd5, 8'h00, 0), cmd(1'b1, 1'b0, 10'd6, 8'h00, 0));
      serve(cmd(1'b1, 1'b0, 10'd7, 8'h00, 0), cmd(1'b1, 1'b0, 10'd8, 8'h00, 0));
      n_checks++;
      if (dut_gnt_log.size() != 4) begin
         n_errors++;
         $display("FAIL grant_order_len: got %0d grants expected 4", dut_gnt_log.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (dut_gnt_log[i] != exp_q[i]) begin
               n_errors++;
               $display("FAIL grant_order[%0d]: got %0d expected %0d", i, dut_gnt_log[i], exp_q[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_coherence();
      serve(cmd(1'b0, 1'b0, '0, '0, 0), cmd(1'b1, 1'b1, 10'd0, 8'h11, 0));
      serve(cmd(1'b1, 1'b0, 10'd0, 8'h00, 0), cmd(1'b0, 1'b0, '0, '0, 0));
   endtask

   task automatic test_busy();
      gnt_cycle[1] = -1;
      serve(cmd(1'b1, 1'b0, 10'd1, 8'h00, 0), cmd(1'b1, 1'b1, 10'd2, 8'h5c, 2));
      n_checks++;
      if (gnt_cycle[1] != 5) begin
         n_errors++;
         $display("FAIL busy_gnt1_cycle: got %0d expected 5", gnt_cycle[1]);
      end
   endtask

   task automatic test_reset_mid_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3; wdata0 = '0;
      tick();
      n_checks++;
      if (gnt0 !== 1'b1) begin
         n_errors++;
         $display("FAIL midrst_gnt0: got %b expected 1", gnt0);
      end
      req0 = 1'b0;
      tick();
      n_checks++;
      if (oe_d !== 1'b1) begin
         n_errors++;
         $display("FAIL midrst_rdwait_oe_d: got %b expected 1", oe_d);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_last = 1;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      n_checks++;
      if ({gnt0, gnt1, ack0, ack1, oe_d, we} !== 6'b0 || data_addr !== '0) begin
         n_errors++;
         $display("FAIL midrst_abort: ctrl got %b addr %0d expected 000000 addr 0",
                  {gnt0, gnt1, ack0, ack1, oe_d, we}, data_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({gnt0, gnt1, ack0, ack1, oe_d, we} !== 6'b0) begin
            n_errors++;
            $display("FAIL midrst_quiet cycle %0d: got %b expected 000000", i,
                     {gnt0, gnt1, ack0, ack1, oe_d, we});
         end
      end
      serve(cmd(1'b1, 1'b1, 10'd3, 8'h5a, 0), cmd(1'b1, 1'b0, 10'd3, 8'h00, 0));
      serve(cmd(1'b1, 1'b0, 10'd3, 8'h00, 0), cmd(1'b0, 1'b0, '0, '0, 0));
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if ({gnt0, gnt1, ack0, ack1, oe_d, we} !== 6'b0) begin
            n_errors++;
            $display("FAIL idle cycle %0d: got %b expected 000000", i,
                     {gnt0, gnt1, ack0, ack1, oe_d, we});
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         int   mode;
         cmd_t a, b;
         mode = int'($urandom_range(0, 2));
         a = cmd(mode != 1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                 8'($urandom), int'($urandom_range(0, 3)));
         b = cmd(mode != 0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
                 8'($urandom), int'($urandom_range(0, 5)));
         serve(a, b);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_simultaneous();
      test_coherence();
      test_busy();
      test_reset_mid_read();
      test_idle();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
